mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
Sequencer that drives one MAC block.
- Accepts a job descriptor, then a byte stream of operands (valid/ready).
- Packs operands into lane registers A0..A3/B1 and pulses the MAC enable once per operation.
- Captures the MAC result and returns it on a valid/ready result stream.
- Sits between the operand DMA/stream fabric and the MAC block.

Parameters:
MIN_W, `MAC_MIN_WIDTH, operand byte width
ACC_W, `MAC_ACC_WIDTH, accumulator/result width
CONF_W, `MAC_CONF_WIDTH, MAC config field width
LEN_W, 16, job length counter width (operations per job)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  descriptor accepted when cfg_valid&cfg_ready
cfg_mode  in  2  `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD
cfg_acc  in  1  1=accumulate job, 0=multiply-only job
cfg_init  in  ACC_W  accumulator initial value
cfg_len  in  LEN_W  number of MAC operations in job
in_valid  in  1  operand byte valid
in_ready  out  1  operand byte accepted on valid&ready
in_data  in  MIN_W  operand byte
in_last  in  1  marks final byte of job (checked only with MAC_FEEDER_ERR_EN)
mac_en  out  1  one-cycle fire pulse to MAC
mac_clr  out  1  one-cycle accumulator clear/init pulse at job start
mac_a0..mac_a3  out  MIN_W each  lane operands
mac_b1  out  MIN_W  shared multiplier operand
mac_cfg  out  ACC_W+CONF_W  {cfg_init, acc_sel, 0.., mode}; acc_sel at bit CONF_W-1, mode at [1:0]
mac_c  in  ACC_W  MAC result
res_valid  out  1  result valid
res_ready  in  1  result accepted on valid&ready
res_data  out  ACC_W  result
res_last  out  1  final result of job
err  out  1  sticky protocol error (0 when feature off)

Behaviour:
- Reset values: all outputs 0 except cfg_ready=1 (IDLE). Reset mid-job aborts the job, discards partial operands and any held result.
- Lane count N: SINGLE=1 (byte into A1), DUAL=2 (A0 then A1), QUAD=4 (A0,A1,A2,A3). Reserved mode 2'b11: N=1, mode passed through unchanged, so the MAC returns 0.
- Per operation, the stream order is N A-bytes, then 1 B-byte.
- States:
  - IDLE: cfg_ready=1. On handshake, latch the descriptor and drive mac_cfg from it, held for the whole job. If cfg_len=0, stay in IDLE; no result, no pulses. Else pulse mac_clr next cycle and go to LOAD_A.
  - LOAD_A: in_ready=1; each accepted byte goes into the next lane. After the Nth byte, go to LOAD_B.
  - LOAD_B: in_ready=1; the accepted byte goes into mac_b1. Go to FIRE.
  - FIRE: mac_en=1 for exactly one cycle, operands stable. Go to WAIT.
  - WAIT: one cycle for the MAC's registered output. At its closing edge, latch mac_c into res_data if the result is due. Result is due every op when cfg_acc=0; only on the final op when cfg_acc=1. If due, go to OUT. Otherwise go to LOAD_A, or to IDLE when the op count reaches cfg_len.
  - OUT: res_valid=1, and res_data/res_last stay stable until res_ready. Then go to LOAD_A, or IDLE after the final op.
- res_last=1 only on the final result of the job.
- Lane registers are not cleared between ops; unused lanes hold stale values and the MAC ignores them by mode.
- in_ready=0 in IDLE/FIRE/WAIT/OUT.
- Only one op is in flight at a time; there is no overlap of load and drain.
- Op counter: LEN_W bits, counts up to cfg_len; there is no wrap inside a job.
- Minimum op latency: N+1 input cycles + FIRE + WAIT, then OUT.

Optional Feature:
MAC_FEEDER_ERR_EN
- With the macro: in_last is checked on every accepted byte.
  - in_last=1 on any byte except the final B-byte, or in_last=0 on the final B-byte, sets err (sticky until reset).
  - The job aborts to IDLE with no further mac_en and no pending result.
- Without the macro: in_last is ignored, err is tied 0, and the check logic is absent.

Decomposition:
- Mode encodings, widths and cfg bit positions come from the shared mac_const.vh; add the FSM state encodings there too.
- One sub-module is natural: mac_lane_packer (lane index counter plus A0..A3/B1 registers with load-enable and mode-dependent lane count).
- FSM, op counter and result register live in the top.

Test Plan:
1. SINGLE, mult-only, len=1: bytes A=0x03, B=0x05 -> mac_en pulse once; res_data=15, res_last=1.
2. DUAL, mult-only, len=1: A0=0x02, A1=0x01, B=0x03 -> res_data=0x0306.
3. SINGLE, accumulate, init=10, len=3: pairs (2,3),(4,5),(1,1) -> exactly one result, =37, res_last=1; three mac_en pulses, one mac_clr.
4. QUAD, mult-only, len=2 with res_ready held low 5 cycles on result 1 -> res_data stable, in_ready=0 while stalled; second result follows with res_last=1.
5. rst asserted mid-LOAD_B, then released -> all outputs 0, cfg_ready=1; a new len=1 job of 7×9 returns 63.
6. MAC_FEEDER_ERR_EN, DUAL len=1, in_last on the A1 byte -> err=1, no mac_en, return to IDLE; cfg_len=0 descriptor -> no result, no pulses.

Source files
------------

// File: rtl/mac_operand_feeder_pkg.sv
//==============================================================================
// Module   : mac_operand_feeder_pkg
// Brief    : Shared MAC widths, mode encodings, cfg bit positions, FSM states.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mac_operand_feeder_pkg;

   localparam int c_mac_min_width  = 8;
   localparam int c_mac_acc_width  = 32;
   localparam int c_mac_conf_width = 4;

   localparam logic [1:0] c_mac_single = 2'b00;
   localparam logic [1:0] c_mac_dual   = 2'b01;
   localparam logic [1:0] c_mac_quad   = 2'b10;
   localparam logic [1:0] c_mac_rsvd   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_FIRE   = 3'd3,
      S_WAIT   = 3'd4,
      S_OUT    = 3'd5
   } feeder_state_t;

   // Reserved mode behaves like SINGLE for packing purposes
   function automatic logic [2:0] lane_count(input logic [1:0] mode);
      case (mode)
         c_mac_dual: return 3'd2;
         c_mac_quad: return 3'd4;
         default:    return 3'd1;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_operand_feeder_packer.sv
//==============================================================================
// Module   : mac_lane_packer
// Brief    : Lane index counter and A0..A3/B1 operand registers.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mac_lane_packer
   import mac_operand_feeder_pkg::*;
#(
   parameter int MIN_W = c_mac_min_width
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             start,
   input  logic             load_a,
   input  logic             load_b,
   input  logic [MIN_W-1:0] data,
   output logic             last_a,
   output logic [MIN_W-1:0] a0,
   output logic [MIN_W-1:0] a1,
   output logic [MIN_W-1:0] a2,
   output logic [MIN_W-1:0] a3,
   output logic [MIN_W-1:0] b1
);

   logic [1:0]       r_idx;
   logic [MIN_W-1:0] r_a0, r_a1, r_a2, r_a3, r_b1;
   logic [2:0]       w_n;
   logic [1:0]       w_lane;

   assign w_n    = lane_count(mode);
   assign last_a = ({1'b0, r_idx} == (w_n - 3'd1));
   // Single-lane modes always land in A1
   assign w_lane = (w_n == 3'd1) ? 2'd1 : r_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx <= 2'd0;
         r_a0  <= '0;
         r_a1  <= '0;
         r_a2  <= '0;
         r_a3  <= '0;
         r_b1  <= '0;
      end else begin
         if (start)
            r_idx <= 2'd0;
         else if (load_a)
            r_idx <= last_a ? 2'd0 : r_idx + 2'd1;
         if (load_a) begin
            case (w_lane)
               2'd0:    r_a0 <= data;
               2'd1:    r_a1 <= data;
               2'd2:    r_a2 <= data;
               default: r_a3 <= data;
            endcase
         end
         if (load_b)
            r_b1 <= data;
      end
   end

   assign a0 = r_a0;
   assign a1 = r_a1;
   assign a2 = r_a2;
   assign a3 = r_a3;
   assign b1 = r_b1;

endmodule

`default_nettype wire

// File: rtl/mac_operand_feeder.sv
//==============================================================================
// Module   : mac_operand_feeder
// Brief    : Job/operand sequencer for one MAC block; optional in_last
//            protocol checking when MAC_FEEDER_ERR_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mac_operand_feeder
   import mac_operand_feeder_pkg::*;
#(
   parameter int MIN_W  = c_mac_min_width,
   parameter int ACC_W  = c_mac_acc_width,
   parameter int CONF_W = c_mac_conf_width,
   parameter int LEN_W  = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [1:0]              cfg_mode,
   input  logic                    cfg_acc,
   input  logic [ACC_W-1:0]        cfg_init,
   input  logic [LEN_W-1:0]        cfg_len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [MIN_W-1:0]        in_data,
   input  logic                    in_last,
   output logic                    mac_en,
   output logic                    mac_clr,
   output logic [MIN_W-1:0]        mac_a0,
   output logic [MIN_W-1:0]        mac_a1,
   output logic [MIN_W-1:0]        mac_a2,
   output logic [MIN_W-1:0]        mac_a3,
   output logic [MIN_W-1:0]        mac_b1,
   output logic [ACC_W+CONF_W-1:0] mac_cfg,
   input  logic [ACC_W-1:0]        mac_c,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [ACC_W-1:0]        res_data,
   output logic                    res_last,
   output logic                    err
);

   feeder_state_t     r_state, w_next;
   logic [1:0]        r_mode;
   logic              r_acc;
   logic [ACC_W-1:0]  r_init;
   logic [LEN_W-1:0]  r_len, r_op_cnt;
   logic [ACC_W-1:0]  r_res_data;
   logic              r_res_last;
   logic              r_clr;
   logic [CONF_W-1:0] w_conf;
   logic              w_cfg_fire, w_in_fire, w_final, w_due, w_abort, w_last_a;

   assign cfg_ready = (r_state == S_IDLE);
   assign in_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   assign mac_en    = (r_state == S_FIRE);
   assign res_valid = (r_state == S_OUT);
   assign mac_clr   = r_clr;
   assign res_data  = r_res_data;
   assign res_last  = r_res_last;

   assign w_cfg_fire = cfg_valid && cfg_ready;
   assign w_in_fire  = in_valid && in_ready;
   // Op counter advances in FIRE, so from WAIT onward it holds completed ops
   assign w_final    = (r_op_cnt == r_len);
   assign w_due      = !r_acc || w_final;

`ifdef MAC_FEEDER_ERR_EN
   logic r_err;
   logic w_last_op;

   assign w_last_op = ((r_op_cnt + LEN_W'(1)) == r_len);
   assign w_abort   = w_in_fire && (in_last != ((r_state == S_LOAD_B) && w_last_op));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_err <= 1'b0;
      else if (w_abort)
         r_err <= 1'b1;
   end

   assign err = r_err;
`else
   logic w_unused_in_last;

   assign w_unused_in_last = in_last;
   assign w_abort          = 1'b0;
   assign err              = 1'b0;
`endif

   always_comb begin
      w_conf           = '0;
      w_conf[CONF_W-1] = r_acc;
      w_conf[1:0]      = r_mode;
   end

   assign mac_cfg = {r_init, w_conf};

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (w_cfg_fire && (cfg_len != '0)) w_next = S_LOAD_A;
         S_LOAD_A: begin
            if (w_abort)                   w_next = S_IDLE;
            else if (w_in_fire && w_last_a) w_next = S_LOAD_B;
         end
         S_LOAD_B: begin
            if (w_abort)        w_next = S_IDLE;
            else if (w_in_fire) w_next = S_FIRE;
         end
         S_FIRE:   w_next = S_WAIT;
         S_WAIT: begin
            if (w_due)        w_next = S_OUT;
            else if (w_final) w_next = S_IDLE;
            else              w_next = S_LOAD_A;
         end
         S_OUT:    if (res_ready) w_next = r_res_last ? S_IDLE : S_LOAD_A;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_mode     <= 2'b00;
         r_acc      <= 1'b0;
         r_init     <= '0;
         r_len      <= '0;
         r_op_cnt   <= '0;
         r_res_data <= '0;
         r_res_last <= 1'b0;
         r_clr      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_clr   <= w_cfg_fire && (cfg_len != '0);
         if (w_cfg_fire) begin
            r_mode   <= cfg_mode;
            r_acc    <= cfg_acc;
            r_init   <= cfg_init;
            r_len    <= cfg_len;
            r_op_cnt <= '0;
         end else if (r_state == S_FIRE) begin
            r_op_cnt <= r_op_cnt + LEN_W'(1);
         end
         if ((r_state == S_WAIT) && w_due) begin
            r_res_data <= mac_c;
            r_res_last <= w_final;
         end
      end
   end

   mac_lane_packer #(
      .MIN_W (MIN_W)
   ) u_packer (
      .clk    (clk),
      .rst    (rst),
      .mode   (r_mode),
      .start  (w_cfg_fire),
      .load_a (w_in_fire && (r_state == S_LOAD_A) && !w_abort),
      .load_b (w_in_fire && (r_state == S_LOAD_B) && !w_abort),
      .data   (in_data),
      .last_a (w_last_a),
      .a0     (mac_a0),
      .a1     (mac_a1),
      .a2     (mac_a2),
      .a3     (mac_a3),
      .b1     (mac_b1)
   );

endmodule

`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
//==============================================================================
// Module   : tb_mac_operand_feeder
// Brief    : Randomized self-checking bench with a behavioural MAC and a
//            job-level reference model of expected results.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mac_operand_feeder;
   import mac_operand_feeder_pkg::*;

   localparam int MIN_W  = c_mac_min_width;
   localparam int ACC_W  = c_mac_acc_width;
   localparam int CONF_W = c_mac_conf_width;
   localparam int LEN_W  = 16;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    cfg_valid = 1'b0, cfg_ready;
   logic [1:0]              cfg_mode = '0;
   logic                    cfg_acc = 1'b0;
   logic [ACC_W-1:0]        cfg_init = '0;
   logic [LEN_W-1:0]        cfg_len = '0;
   logic                    in_valid = 1'b0, in_ready, in_last = 1'b0;
   logic [MIN_W-1:0]        in_data = '0;
   logic                    mac_en, mac_clr;
   logic [MIN_W-1:0]        mac_a0, mac_a1, mac_a2, mac_a3, mac_b1;
   logic [ACC_W+CONF_W-1:0] mac_cfg;
   logic [ACC_W-1:0]        mac_c = '0;
   logic                    res_valid, res_ready = 1'b0, res_last, err;
   logic [ACC_W-1:0]        res_data;

   int checks = 0;
   int failures = 0;
   int en_cnt = 0;
   int clr_cnt = 0;
   bit stall_ok;
   logic [7:0]  job_bytes[$];
   logic [31:0] exp_d[$];
   logic [31:0] got_d[$];
   logic        got_l[$];
   logic [31:0] mac_acc_m = '0;

   always #5 clk = ~clk;

   mac_operand_feeder #(.MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_acc(cfg_acc),
      .cfg_init(cfg_init), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .mac_en(mac_en), .mac_clr(mac_clr),
      .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3), .mac_b1(mac_b1),
      .mac_cfg(mac_cfg), .mac_c(mac_c),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .err(err)
   );

   // Behavioural MAC: single -> A1*B, dual -> packed 8-bit lane products, quad -> dot product
   function automatic logic [31:0] mac_fn(input logic [1:0] m, input logic [7:0] x0, x1, x2, x3, b);
      logic [15:0] p0, p1, p2, p3;
      p0 = {8'd0, x0} * {8'd0, b};
      p1 = {8'd0, x1} * {8'd0, b};
      p2 = {8'd0, x2} * {8'd0, b};
      p3 = {8'd0, x3} * {8'd0, b};
      case (m)
         c_mac_single: return {16'd0, p1};
         c_mac_dual:   return {16'd0, p1[7:0], p0[7:0]};
         c_mac_quad:   return {16'd0, p0} + {16'd0, p1} + {16'd0, p2} + {16'd0, p3};
         default:      return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mac_clr) mac_acc_m = mac_cfg[ACC_W+CONF_W-1:CONF_W];
      if (mac_en) begin
         if (mac_cfg[CONF_W-1]) begin
            mac_acc_m = mac_acc_m + mac_fn(mac_cfg[1:0], mac_a0, mac_a1, mac_a2, mac_a3, mac_b1);
            mac_c <= mac_acc_m;
         end else begin
            mac_c <= mac_fn(mac_cfg[1:0], mac_a0, mac_a1, mac_a2, mac_a3, mac_b1);
         end
      end
   end

   always @(negedge clk) begin
      if (mac_en === 1'b1)  en_cnt++;
      if (mac_clr === 1'b1) clr_cnt++;
   end

   // ---------------- job-level reference model ----------------
   function automatic int lanes_of(input logic [1:0] m);
      return (m == c_mac_dual) ? 2 : (m == c_mac_quad) ? 4 : 1;
   endfunction

   function automatic logic [31:0] ref_prod(input logic [1:0] m, input int p);
      int b, s;
      b = int'(job_bytes[p + lanes_of(m)]);
      s = 0;
      if (m == c_mac_single)    s = int'(job_bytes[p]) * b;
      else if (m == c_mac_dual) s = (((int'(job_bytes[p+1]) * b) % 256) * 256) + ((int'(job_bytes[p]) * b) % 256);
      else if (m == c_mac_quad) for (int k = 0; k < 4; k++) s += int'(job_bytes[p+k]) * b;
      return 32'(s);
   endfunction

   task automatic ref_model(input logic [1:0] m, input bit acc, input logic [31:0] init, input int len);
      int p;
      logic [31:0] sum;
      exp_d.delete();
      p = 0;
      sum = init;
      for (int k = 0; k < len; k++) begin
         if (acc) sum = sum + ref_prod(m, p);
         else     exp_d.push_back(ref_prod(m, p));
         p += lanes_of(m) + 1;
      end
      if (acc) exp_d.push_back(sum);
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (i < got_d.size()) ? got_d[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic got_last_at(input int i);
      return (i < got_l.size()) ? got_l[i] : 1'bx;
   endfunction

   // ---------------- drivers ----------------
   task automatic timeout_fail(input string what);
      checks++;
      failures++;
      $display("FAIL timeout_%s waited too long, got=no handshake exp=handshake", what);
   endtask

   task automatic send_cfg(input logic [1:0] m, input bit acc, input logic [31:0] init, input int len);
      int t;
      cfg_mode = m; cfg_acc = acc; cfg_init = init; cfg_len = LEN_W'(len); cfg_valid = 1'b1;
      t = 0;
      while (!cfg_ready && t < 100) begin @(negedge clk); t++; end
      if (!cfg_ready) timeout_fail("cfg");
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last);
      int t;
      in_valid = 1'b1; in_data = d; in_last = last;
      t = 0;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (!in_ready) timeout_fail("in");
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic run_job(input logic [1:0] m, input bit acc, input logic [31:0] init,
                          input int len, input int nres, input int stall0);
      got_d.delete(); got_l.delete();
      stall_ok = 1'b1;
      send_cfg(m, acc, init, len);
      fork
         begin
            for (int i = 0; i < job_bytes.size(); i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               send_byte(job_bytes[i], i == job_bytes.size() - 1);
            end
         end
         begin
            for (int r = 0; r < nres; r++) begin
               int tr, st;
               logic [31:0] d0;
               logic l0;
               tr = 0;
               while (!res_valid && tr < 400) begin @(negedge clk); tr++; end
               if (!res_valid) begin timeout_fail("res"); break; end
               st = (r == 0) ? stall0 : int'($urandom_range(0, 2));
               d0 = res_data; l0 = res_last;
               repeat (st) begin
                  @(negedge clk);
                  if (res_data !== d0 || res_last !== l0 || res_valid !== 1'b1 || in_ready !== 1'b0) stall_ok = 1'b0;
               end
               got_d.push_back(res_data); got_l.push_back(res_last);
               res_ready = 1'b1;
               @(negedge clk);
               res_ready = 1'b0;
            end
         end
      join
      repeat (3) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
      checks++;
      if ({in_ready, mac_en, mac_clr, res_valid, res_last, err} !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=000000", {in_ready, mac_en, mac_clr, res_valid, res_last, err});
      end
      checks++;
      if ({mac_a0, mac_a1, mac_a2, mac_a3, mac_b1, mac_cfg, res_data} !== '0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", {mac_a0, mac_a1, mac_a2, mac_a3, mac_b1, mac_cfg, res_data});
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int e0, c0;
      e0 = en_cnt; c0 = clr_cnt;
      job_bytes = '{8'h03, 8'h05};
      run_job(c_mac_single, 1'b0, 32'd0, 1, 1, 0);
      checks++;
      if (got_at(0) !== 32'd15 || got_last_at(0) !== 1'b1 || got_d.size() != 1) begin
         failures++; $display("FAIL single_result got=%0d/%b n=%0d exp=15/1 n=1", got_at(0), got_last_at(0), got_d.size());
      end
      checks++;
      if (en_cnt - e0 != 1 || clr_cnt - c0 != 1) begin
         failures++; $display("FAIL single_pulses got en=%0d clr=%0d exp en=1 clr=1", en_cnt - e0, clr_cnt - c0);
      end
   endtask

   task automatic test_dual();
      job_bytes = '{8'h02, 8'h01, 8'h03};
      run_job(c_mac_dual, 1'b0, 32'd0, 1, 1, 0);
      checks++;
      if (got_at(0) !== 32'h0306 || got_last_at(0) !== 1'b1) begin
         failures++; $display("FAIL dual_result got=%h/%b exp=0306/1", got_at(0), got_last_at(0));
      end
      checks++;
      if (mac_a0 !== 8'h02 || mac_a1 !== 8'h01 || mac_b1 !== 8'h03) begin
         failures++; $display("FAIL dual_lanes got a0=%h a1=%h b1=%h exp a0=02 a1=01 b1=03", mac_a0, mac_a1, mac_b1);
      end
   endtask

   task automatic test_accumulate();
      int e0, c0;
      e0 = en_cnt; c0 = clr_cnt;
      job_bytes = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd1};
      run_job(c_mac_single, 1'b1, 32'd10, 3, 1, 0);
      repeat (20) @(negedge clk);
      checks++;
      if (got_at(0) !== 32'd37 || got_last_at(0) !== 1'b1 || got_d.size() != 1 || res_valid !== 1'b0) begin
         failures++; $display("FAIL acc_result got=%0d/%b n=%0d exp=37/1 n=1", got_at(0), got_last_at(0), got_d.size());
      end
      checks++;
      if (en_cnt - e0 != 3 || clr_cnt - c0 != 1) begin
         failures++; $display("FAIL acc_pulses got en=%0d clr=%0d exp en=3 clr=1", en_cnt - e0, clr_cnt - c0);
      end
      checks++;
      if (mac_cfg !== {32'd10, 4'b1000}) begin
         failures++; $display("FAIL acc_cfg got=%h exp=%h", mac_cfg, {32'd10, 4'b1000});
      end
   endtask

   task automatic test_quad_stall();
      job_bytes.delete();
      repeat (10) job_bytes.push_back(8'($urandom));
      ref_model(c_mac_quad, 1'b0, 32'd0, 2);
      run_job(c_mac_quad, 1'b0, 32'd0, 2, 2, 5);
      checks++;
      if (stall_ok !== 1'b1) begin failures++; $display("FAIL quad_stall_stable got=%b exp=1", stall_ok); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (got_at(i) !== exp_d[i] || got_last_at(i) !== (i == 1)) begin
            failures++; $display("FAIL quad_res%0d got=%h/%b exp=%h/%b", i, got_at(i), got_last_at(i), exp_d[i], i == 1);
         end
      end
   endtask

   task automatic test_reset_midjob();
      send_cfg(c_mac_single, 1'b0, 32'd0, 1);
      send_byte(8'h11, 1'b0);
      checks++;
      if (in_ready !== 1'b1 || mac_a1 !== 8'h11) begin
         failures++; $display("FAIL midjob_loadb got in_ready=%b a1=%h exp in_ready=1 a1=11", in_ready, mac_a1);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (cfg_ready !== 1'b1 || {in_ready, mac_en, mac_clr, res_valid, res_last, err, mac_a1, mac_cfg, res_data} !== '0) begin
         failures++; $display("FAIL midjob_reset got cfg_ready=%b in_ready=%b a1=%h exp cfg_ready=1 rest=0", cfg_ready, in_ready, mac_a1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      job_bytes = '{8'd7, 8'd9};
      run_job(c_mac_single, 1'b0, 32'd0, 1, 1, 0);
      checks++;
      if (got_at(0) !== 32'd63 || got_last_at(0) !== 1'b1) begin
         failures++; $display("FAIL midjob_rerun got=%0d/%b exp=63/1", got_at(0), got_last_at(0));
      end
   endtask

   task automatic test_zero_len();
      int e0, c0;
      bit seen;
      e0 = en_cnt; c0 = clr_cnt; seen = 1'b0;
      send_cfg(c_mac_dual, 1'b0, 32'd5, 0);
      repeat (10) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || in_ready !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen || cfg_ready !== 1'b1 || en_cnt != e0 || clr_cnt != c0) begin
         failures++; $display("FAIL zero_len got activity=%b cfg_ready=%b en=%0d clr=%0d exp 0/1/0/0", seen, cfg_ready, en_cnt - e0, clr_cnt - c0);
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 8; j++) begin
         logic [1:0]  m;
         bit          acc;
         logic [31:0] init;
         int          len, e0, c0;
         m = 2'($urandom_range(0, 3));
         acc = 1'($urandom_range(0, 1));
         init = $urandom;
         len = int'($urandom_range(1, 4));
         job_bytes.delete();
         repeat (len * (lanes_of(m) + 1)) job_bytes.push_back(8'($urandom));
         ref_model(m, acc, init, len);
         e0 = en_cnt; c0 = clr_cnt;
         run_job(m, acc, init, len, exp_d.size(), int'($urandom_range(0, 3)));
         checks++;
         if (got_d.size() != exp_d.size() || en_cnt - e0 != len || clr_cnt - c0 != 1) begin
            failures++; $display("FAIL rand%0d_counts got n=%0d en=%0d clr=%0d exp n=%0d en=%0d clr=1", j, got_d.size(), en_cnt - e0, clr_cnt - c0, exp_d.size(), len);
         end
         for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (got_at(i) !== exp_d[i] || got_last_at(i) !== (i == exp_d.size() - 1)) begin
               failures++; $display("FAIL rand%0d_res%0d mode=%0d acc=%0d got=%h/%b exp=%h/%b", j, i, m, acc, got_at(i), got_last_at(i), exp_d[i], i == exp_d.size() - 1);
            end
         end
      end
   endtask

`ifdef MAC_FEEDER_ERR_EN
   task automatic test_err();
      int e0;
      e0 = en_cnt;
      send_cfg(c_mac_dual, 1'b0, 32'd0, 1);
      send_byte(8'h04, 1'b0);
      send_byte(8'h05, 1'b1);
      repeat (6) @(negedge clk);
      checks++;
      if (err !== 1'b1 || cfg_ready !== 1'b1 || en_cnt != e0 || res_valid !== 1'b0) begin
         failures++; $display("FAIL err_abort got err=%b cfg_ready=%b en=%0d exp err=1 cfg_ready=1 en=0", err, cfg_ready, en_cnt - e0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_dual();
      test_accumulate();
      test_quad_stall();
      test_reset_midjob();
      test_zero_len();
      test_random();
`ifdef MAC_FEEDER_ERR_EN
      test_err();
`else
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL err_tied got=%b exp=0", err); end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
